// File: rtl/jb_hw_ctrl_pkg.sv
// Shared types and constants for the jb_hw_ctrl hardware-side block.
`timescale 1ns/1ps
package jb_hw_ctrl_pkg;

  localparam int NUM_CH  = 8;
  localparam int DSA_W   = 7;
  localparam int GUARD_W = 16;

  localparam logic [DSA_W-1:0] DSA_MAX = 7'h7F;

  // Bit positions inside cal_sw_o = {tx_ant_cal_en, rx_ant_cal_en}
  localparam int CAL_SW_RX_BIT = 0;
  localparam int CAL_SW_TX_BIT = 1;

  typedef enum logic [1:0] {
    RX       = 2'd0,
    TX_GUARD = 2'd1,
    TX       = 2'd2,
    RX_GUARD = 2'd3
  } tdd_state_t;

  // Guard states are the only ones in which both PA and LNA must stay off
  function automatic logic is_guard(input tdd_state_t st);
    return (st == TX_GUARD) || (st == RX_GUARD);
  endfunction

endpackage

// File: rtl/jb_hw_ctrl_if.sv
// Register-file <-> hardware-block control bundle.
`timescale 1ns/1ps
interface jb_hw_ctrl_if;
  import jb_hw_ctrl_pkg::*;

  // Register-file driven controls
  logic [GUARD_W-1:0]             ant_switch_delay;
  logic [1:0]                     pa_lna_en;
  logic [NUM_CH-1:0]              tdd_ctrl_pa;
  logic                           pa_resetn;
  logic [NUM_CH-1:0]              bypass_lna;
  logic                           rf_switch_override;
  logic [NUM_CH-1:0][DSA_W-1:0]   ps_rxdsa;
  logic                           cold_rst_n;
  logic                           cold_rst_n_mask;
  logic                           tx_ant_cal_en;
  logic                           rx_ant_cal_en;

  // Status returned to the register file
  logic [NUM_CH-1:0][DSA_W-1:0]   pl_rxdsa;
  logic [NUM_CH-1:0]              pa_v_pgood;
  logic                           aisg_pgood;

  modport ctrl (
    output ant_switch_delay, pa_lna_en, tdd_ctrl_pa, pa_resetn, bypass_lna,
           rf_switch_override, ps_rxdsa, cold_rst_n, cold_rst_n_mask,
           tx_ant_cal_en, rx_ant_cal_en,
    input  pl_rxdsa, pa_v_pgood, aisg_pgood
  );

  modport blk (
    input  ant_switch_delay, pa_lna_en, tdd_ctrl_pa, pa_resetn, bypass_lna,
           rf_switch_override, ps_rxdsa, cold_rst_n, cold_rst_n_mask,
           tx_ant_cal_en, rx_ant_cal_en,
    output pl_rxdsa, pa_v_pgood, aisg_pgood
  );

endinterface

// File: rtl/jb_sync_debounce.sv
// Multi-flop synchronizer with optional consecutive-sample debounce filter.
// DEBOUNCE_CYCLES=0 gives a plain synchronizer.
`timescale 1ns/1ps
module jb_sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   synced;

  // Shift chain bringing the asynchronous pin into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= '0;
    else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
  end

  assign synced = sync_reg[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_plain
      assign dout = synced;
    end else begin : g_filt
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt_reg;
      logic             out_reg;

      // Accept a new level only after an unbroken run of differing samples
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
          out_reg <= 1'b0;
        end else if (synced == out_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          out_reg <= synced;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign dout = out_reg;
    end
  endgenerate

endmodule

// File: rtl/jb_hw_ctrl_blk.sv
// Hardware-side endpoint of jb_hw_ctrl_if: TDD PA/LNA gating with antenna
// guard time, RX DSA application, cold-reset pulse and pgood filtering.
`timescale 1ns/1ps
module jb_hw_ctrl_blk
  import jb_hw_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 1024,
  parameter int RST_PULSE_CYCLES = 256,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  jb_hw_ctrl_if.blk                    hw_ctrl,
  input  logic                         tdd_tx_pin,
  input  logic [NUM_CH-1:0]            pa_v_pgood_pin,
  input  logic                         aisg_pgood_pin,
  output logic [NUM_CH-1:0]            pa_en_o,
  output logic [NUM_CH-1:0]            lna_en_o,
  output logic [NUM_CH-1:0][DSA_W-1:0] rxdsa_o,
  output logic [1:0]                   cal_sw_o,
  output logic                         cold_rst_pin_n
);

  localparam int PULSE_W = $clog2(RST_PULSE_CYCLES + 1);

  // ---------------------------------------------------------------- inputs
  logic              tdd_tx_s;
  logic [NUM_CH-1:0] pa_pgood_w;
  logic              aisg_pgood_w;

  jb_sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(0)) u_tdd_sync (
    .clk(clk), .rst(rst), .din(tdd_tx_pin), .dout(tdd_tx_s)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_pa_pgood
      jb_sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_flt (
        .clk(clk), .rst(rst), .din(pa_v_pgood_pin[gi]), .dout(pa_pgood_w[gi])
      );
    end
  endgenerate

  jb_sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_aisg_flt (
    .clk(clk), .rst(rst), .din(aisg_pgood_pin), .dout(aisg_pgood_w)
  );

  assign hw_ctrl.pa_v_pgood = pa_pgood_w;
  assign hw_ctrl.aisg_pgood = aisg_pgood_w;

  // --------------------------------------------------------------- TDD FSM
  tdd_state_t         state_reg, state_next;
  logic [GUARD_W-1:0] guard_cnt_reg, guard_cnt_next;
  logic               guard_done;
  logic               override;

  assign override   = hw_ctrl.rf_switch_override;
  // A load of 0 or 1 both mean a single guard cycle
  assign guard_done = (guard_cnt_reg <= GUARD_W'(1));

  // State and guard counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= RX;
      guard_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      guard_cnt_reg <= guard_cnt_next;
    end
  end

  // Next state: reversals reload the guard, override drives toward RX
  always_comb begin
    state_next     = state_reg;
    guard_cnt_next = guard_cnt_reg;
    case (state_reg)
      RX: begin
        if (!override && tdd_tx_s) begin
          state_next     = TX_GUARD;
          guard_cnt_next = hw_ctrl.ant_switch_delay;
        end
      end
      TX_GUARD: begin
        if (override || !tdd_tx_s) begin
          state_next     = RX_GUARD;
          guard_cnt_next = hw_ctrl.ant_switch_delay;
        end else if (guard_done) begin
          state_next     = TX;
          guard_cnt_next = '0;
        end else begin
          guard_cnt_next = guard_cnt_reg - GUARD_W'(1);
        end
      end
      TX: begin
        if (override || !tdd_tx_s) begin
          state_next     = RX_GUARD;
          guard_cnt_next = hw_ctrl.ant_switch_delay;
        end
      end
      RX_GUARD: begin
        if (!override && tdd_tx_s) begin
          state_next     = TX_GUARD;
          guard_cnt_next = hw_ctrl.ant_switch_delay;
        end else if (guard_done) begin
          state_next     = RX;
          guard_cnt_next = '0;
        end else begin
          guard_cnt_next = guard_cnt_reg - GUARD_W'(1);
        end
      end
      default: begin
        state_next     = RX;
        guard_cnt_next = '0;
      end
    endcase
  end

  // ------------------------------------------------------- RF pin drives
  logic [NUM_CH-1:0] pa_en_reg, lna_en_reg;
  logic [1:0]        cal_sw_reg;

  // PA/LNA enables follow the state one cycle later; guards force both off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pa_en_reg  <= '0;
      lna_en_reg <= '0;
      cal_sw_reg <= '0;
    end else begin
      pa_en_reg  <= (state_reg == TX && hw_ctrl.pa_lna_en[0] && hw_ctrl.pa_resetn)
                    ? hw_ctrl.tdd_ctrl_pa : '0;
      lna_en_reg <= (state_reg == RX && hw_ctrl.pa_lna_en[1] && !is_guard(state_reg))
                    ? ~hw_ctrl.bypass_lna : '0;
      cal_sw_reg[CAL_SW_TX_BIT] <= hw_ctrl.tx_ant_cal_en;
      cal_sw_reg[CAL_SW_RX_BIT] <= hw_ctrl.rx_ant_cal_en;
    end
  end

  assign pa_en_o  = pa_en_reg;
  assign lna_en_o = lna_en_reg;
  assign cal_sw_o = cal_sw_reg;

  // ---------------------------------------------------------------- RX DSA
  logic [NUM_CH-1:0][DSA_W-1:0] rxdsa_reg, pl_rxdsa_reg;
  logic                         dsa_load;

  // Gain steps only outside receive, unless the override pins us in RX
  assign dsa_load = (state_reg != RX) || override;

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_dsa
      // Per-channel applied code and its status mirror
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rxdsa_reg[gi]    <= DSA_MAX;
          pl_rxdsa_reg[gi] <= DSA_MAX;
        end else begin
          if (dsa_load) rxdsa_reg[gi] <= hw_ctrl.ps_rxdsa[gi];
          pl_rxdsa_reg[gi] <= rxdsa_reg[gi];
        end
      end
    end
  endgenerate

  assign rxdsa_o          = rxdsa_reg;
  assign hw_ctrl.pl_rxdsa = pl_rxdsa_reg;

  // ------------------------------------------------------------ cold reset
  logic [PULSE_W-1:0] pulse_cnt_reg;
  logic               cold_rst_n_d_reg;
  logic               rst_pin_n_reg;

  // Falling edge of cold_rst_n starts a fixed-width, non-retriggerable pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_cnt_reg    <= '0;
      cold_rst_n_d_reg <= 1'b1;
      rst_pin_n_reg    <= 1'b1;
    end else begin
      cold_rst_n_d_reg <= hw_ctrl.cold_rst_n;
      if (pulse_cnt_reg != '0) begin
        pulse_cnt_reg <= pulse_cnt_reg - PULSE_W'(1);
        if (pulse_cnt_reg == PULSE_W'(1)) rst_pin_n_reg <= 1'b1;
      end else if (cold_rst_n_d_reg && !hw_ctrl.cold_rst_n && !hw_ctrl.cold_rst_n_mask) begin
        pulse_cnt_reg <= PULSE_W'(RST_PULSE_CYCLES);
        rst_pin_n_reg <= 1'b0;
      end
    end
  end

  assign cold_rst_pin_n = rst_pin_n_reg;

endmodule

// File: tb/tb_jb_hw_ctrl_blk.sv
// Directed self-checking bench for jb_hw_ctrl_blk.
`timescale 1ns/1ps
module tb_jb_hw_ctrl_blk;
  import jb_hw_ctrl_pkg::*;

  localparam logic [55:0] DSA_ALL_MAX = {8{7'h7F}};

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         tdd_tx_pin;
  logic [NUM_CH-1:0]            pa_v_pgood_pin;
  logic                         aisg_pgood_pin;
  logic [NUM_CH-1:0]            pa_en_o;
  logic [NUM_CH-1:0]            lna_en_o;
  logic [NUM_CH-1:0][DSA_W-1:0] rxdsa_o;
  logic [1:0]                   cal_sw_o;
  logic                         cold_rst_pin_n;

  int checks = 0;
  int errors = 0;
  logic [NUM_CH-1:0] pa_or;

  jb_hw_ctrl_if hw_if ();

  jb_hw_ctrl_blk #(
    .DEBOUNCE_CYCLES(1024), .RST_PULSE_CYCLES(256), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .hw_ctrl(hw_if),
    .tdd_tx_pin(tdd_tx_pin), .pa_v_pgood_pin(pa_v_pgood_pin),
    .aisg_pgood_pin(aisg_pgood_pin), .pa_en_o(pa_en_o), .lna_en_o(lna_en_o),
    .rxdsa_o(rxdsa_o), .cal_sw_o(cal_sw_o), .cold_rst_pin_n(cold_rst_pin_n)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and land 1 ns after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    tdd_tx_pin = 1'b0;
    pa_v_pgood_pin = '0;
    aisg_pgood_pin = 1'b0;
    hw_if.ant_switch_delay = '0;
    hw_if.pa_lna_en = '0;
    hw_if.tdd_ctrl_pa = '0;
    hw_if.pa_resetn = 1'b0;
    hw_if.bypass_lna = '0;
    hw_if.rf_switch_override = 1'b0;
    for (int i = 0; i < NUM_CH; i++) hw_if.ps_rxdsa[i] = 7'h7F;
    hw_if.cold_rst_n = 1'b1;
    hw_if.cold_rst_n_mask = 1'b0;
    hw_if.tx_ant_cal_en = 1'b0;
    hw_if.rx_ant_cal_en = 1'b0;

    // 1. reset state and pgood filtering
    tick(3);
    rst = 1'b0;
    tick(2);
    check("rst_rxdsa", rxdsa_o, DSA_ALL_MAX);
    check("rst_pgood", hw_if.pa_v_pgood, 8'h00);
    check("rst_pin_n", cold_rst_pin_n, 1'b1);
    check("rst_pa_en", pa_en_o, 8'h00);

    pa_v_pgood_pin = 8'hFF;
    aisg_pgood_pin = 1'b1;
    tick(500);
    pa_v_pgood_pin = 8'hFE;
    tick(1);
    pa_v_pgood_pin = 8'hFF;
    tick(524);
    check("pgood_at_1025", hw_if.pa_v_pgood, 8'h00);
    check("aisg_at_1025", hw_if.aisg_pgood, 1'b0);
    tick(1);
    check("pgood_at_1026", hw_if.pa_v_pgood, 8'hFE);
    check("aisg_at_1026", hw_if.aisg_pgood, 1'b1);
    tick(500);
    check("glitch_at_1526", hw_if.pa_v_pgood, 8'hFE);
    tick(1);
    check("glitch_at_1527", hw_if.pa_v_pgood, 8'hFF);

    // 2. TDD gating with a 10-cycle guard
    hw_if.ant_switch_delay = 16'd10;
    hw_if.pa_lna_en = 2'b11;
    hw_if.tdd_ctrl_pa = 8'h0F;
    hw_if.pa_resetn = 1'b1;
    hw_if.bypass_lna = 8'hA5;
    hw_if.tx_ant_cal_en = 1'b1;
    tick(3);
    check("rx_lna", lna_en_o, 8'h5A);
    check("cal_sw_tx", cal_sw_o, 2'b10);
    check("rx_pa_off", pa_en_o, 8'h00);
    tdd_tx_pin = 1'b1;
    tick(3);
    check("tx_edge_lna_3", lna_en_o, 8'h5A);
    tick(1);
    check("txg_lna_off", lna_en_o, 8'h00);
    check("txg_pa_off", pa_en_o, 8'h00);
    tick(9);
    check("txg_pa_end", pa_en_o, 8'h00);
    tick(1);
    check("tx_pa_on", pa_en_o, 8'h0F);
    check("tx_lna_off", lna_en_o, 8'h00);
    tdd_tx_pin = 1'b0;
    tick(3);
    check("rx_edge_pa_3", pa_en_o, 8'h0F);
    tick(1);
    check("rxg_pa_off", pa_en_o, 8'h00);
    tick(9);
    check("rxg_lna_end", lna_en_o, 8'h00);
    tick(1);
    check("rx_lna_on", lna_en_o, 8'h5A);

    // 3. zero-delay guard, then reversal mid-guard at delay 100
    hw_if.ant_switch_delay = 16'd0;
    tdd_tx_pin = 1'b1;
    tick(4);
    check("d0_pa_guard", pa_en_o, 8'h00);
    tick(1);
    check("d0_pa_on", pa_en_o, 8'h0F);
    tdd_tx_pin = 1'b0;
    tick(4);
    check("d0_lna_guard", lna_en_o, 8'h00);
    tick(1);
    check("d0_lna_on", lna_en_o, 8'h5A);

    hw_if.ant_switch_delay = 16'd100;
    tdd_tx_pin = 1'b1;
    pa_or = '0;
    for (int c = 0; c < 50; c++) begin
      tick(1);
      pa_or = pa_or | pa_en_o;
    end
    tdd_tx_pin = 1'b0;
    for (int c = 0; c < 70; c++) begin
      tick(1);
      pa_or = pa_or | pa_en_o;
    end
    check("rev_lna_120", lna_en_o, 8'h00);
    for (int c = 0; c < 33; c++) begin
      tick(1);
      pa_or = pa_or | pa_en_o;
    end
    check("rev_lna_153", lna_en_o, 8'h00);
    tick(1);
    check("rev_lna_154", lna_en_o, 8'h5A);
    check("rev_pa_never", pa_or, 8'h00);

    // 4. RX DSA application and override
    hw_if.ant_switch_delay = 16'd10;
    hw_if.ps_rxdsa[0] = 7'h20;
    tick(5);
    check("dsa_hold_rx", rxdsa_o[0], 7'h7F);
    tdd_tx_pin = 1'b1;
    tick(3);
    check("dsa_hold_3", rxdsa_o[0], 7'h7F);
    tick(1);
    check("dsa_load_txg", rxdsa_o[0], 7'h20);
    check("pl_dsa_lag", hw_if.pl_rxdsa[0], 7'h7F);
    tick(1);
    check("pl_dsa_load", hw_if.pl_rxdsa[0], 7'h20);
    tdd_tx_pin = 1'b0;
    tick(20);
    hw_if.ps_rxdsa[1] = 7'h33;
    hw_if.rf_switch_override = 1'b1;
    tick(1);
    check("ovr_dsa_now", rxdsa_o[1], 7'h33);
    tdd_tx_pin = 1'b1;
    tick(20);
    check("ovr_pin_lna", lna_en_o, 8'h5A);
    check("ovr_pin_pa", pa_en_o, 8'h00);
    hw_if.rf_switch_override = 1'b0;
    tick(15);
    check("ovr_clr_pa", pa_en_o, 8'h0F);
    hw_if.rf_switch_override = 1'b1;
    tick(2);
    check("ovr_tx_pa_off", pa_en_o, 8'h00);
    tick(9);
    check("ovr_rxg_lna", lna_en_o, 8'h00);
    tick(1);
    check("ovr_rx_lna", lna_en_o, 8'h5A);
    tdd_tx_pin = 1'b0;
    tick(3);
    hw_if.rf_switch_override = 1'b0;
    tick(2);

    // 5. cold reset pulse
    hw_if.cold_rst_n = 1'b0;
    tick(1);
    check("crst_start", cold_rst_pin_n, 1'b0);
    tick(49);
    hw_if.cold_rst_n = 1'b1;
    tick(50);
    hw_if.cold_rst_n = 1'b0;
    tick(156);
    check("crst_256", cold_rst_pin_n, 1'b0);
    tick(1);
    check("crst_257", cold_rst_pin_n, 1'b1);
    tick(50);
    check("crst_no_repeat", cold_rst_pin_n, 1'b1);
    hw_if.cold_rst_n = 1'b1;
    hw_if.cold_rst_n_mask = 1'b1;
    tick(2);
    hw_if.cold_rst_n = 1'b0;
    tick(5);
    check("crst_masked", cold_rst_pin_n, 1'b1);
    hw_if.cold_rst_n = 1'b1;
    hw_if.cold_rst_n_mask = 1'b0;
    tick(2);
    hw_if.cold_rst_n = 1'b0;
    tick(10);
    hw_if.cold_rst_n_mask = 1'b1;
    tick(246);
    check("crst_mask_mid", cold_rst_pin_n, 1'b0);
    tick(1);
    check("crst_mask_end", cold_rst_pin_n, 1'b1);
    hw_if.cold_rst_n = 1'b1;
    hw_if.cold_rst_n_mask = 1'b0;
    tick(2);

    // 6. asynchronous reset during TX and mid-pulse
    hw_if.rx_ant_cal_en = 1'b1;
    tdd_tx_pin = 1'b1;
    tick(20);
    check("pre_rst_pa", pa_en_o, 8'h0F);
    hw_if.cold_rst_n = 1'b0;
    tick(10);
    check("pre_rst_pin", cold_rst_pin_n, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("arst_pa", pa_en_o, 8'h00);
    check("arst_lna", lna_en_o, 8'h00);
    check("arst_cal", cal_sw_o, 2'b00);
    check("arst_rxdsa", rxdsa_o, DSA_ALL_MAX);
    check("arst_pl_rxdsa", hw_if.pl_rxdsa, DSA_ALL_MAX);
    check("arst_pgood", hw_if.pa_v_pgood, 8'h00);
    check("arst_aisg", hw_if.aisg_pgood, 1'b0);
    check("arst_pin_n", cold_rst_pin_n, 1'b1);
    #2;
    rst = 1'b0;
    tick(1);
    check("post_rst_lna", lna_en_o, 8'h5A);
    check("post_rst_pa", pa_en_o, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jb_hw_ctrl_blk.md
Name: jb_hw_ctrl_blk

Overview:
Hardware-side endpoint of jb_hw_ctrl_if; connects to the blk modport, opposite the register-file ctrl side.
- Converts register controls into timed board pin drives: TDD PA/LNA gating with antenna-switch guard time, RX DSA application and cold-reset pulse.
- Returns filtered status to the register file: pgood bits and applied DSA codes.
- Sits in the radio top level between the regmap and the FPGA I/O pins.

Parameters:
DEBOUNCE_CYCLES, 1024, consecutive stable cycles before a synchronized pgood input is accepted
RST_PULSE_CYCLES, 256, width of the cold_rst_pin_n low pulse in clk cycles
SYNC_STAGES, 2, flop count on every asynchronous pin input (legal values 2..4)

Ports:
clk  input  1  single system clock
rst  input  1  asynchronous, active-high reset
hw_ctrl  modport  jb_hw_ctrl_if.blk  register controls in; pl_rxdsa, pa_v_pgood, aisg_pgood out
tdd_tx_pin  input  1  asynchronous TDD timing: 1 = TX period, 0 = RX period
pa_v_pgood_pin  input  8  asynchronous PA supply power-good pins
aisg_pgood_pin  input  1  asynchronous AISG supply power-good pin
pa_en_o  output  8  per-channel PA enable
lna_en_o  output  8  per-channel LNA enable
rxdsa_o  output  8x7  per-channel RX DSA attenuation code
cal_sw_o  output  2  {tx_ant_cal_en, rx_ant_cal_en}, registered
cold_rst_pin_n  output  1  board cold reset, active low

Behaviour:
Reset values (asynchronous, while rst=1):
- pa_en_o=0, lna_en_o=0, cal_sw_o=0.
- rxdsa_o=all 7'h7F (maximum attenuation); hw_ctrl.pl_rxdsa=all 7'h7F.
- hw_ctrl.pa_v_pgood=0, hw_ctrl.aisg_pgood=0.
- cold_rst_pin_n=1; FSM=RX; all counters 0.

Input conditioning:
- Every *_pin input passes through SYNC_STAGES flops.
- pgood filter: one counter per bit. Output bit changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any matching sample clears the counter.
- Total latency for a pgood change: SYNC_STAGES + DEBOUNCE_CYCLES cycles.

TDD FSM (states RX, TX_GUARD, TX, RX_GUARD), driven by synchronized tdd_tx:
- RX: tdd_tx=1 -> TX_GUARD; load guard counter with ant_switch_delay.
- TX_GUARD: counter decrements each cycle; leave when it reaches 0 -> TX. Guard lasts max(ant_switch_delay,1) cycles.
- TX: tdd_tx=0 -> RX_GUARD; load counter the same way.
- RX_GUARD: counter reaches 0 -> RX.
- A tdd_tx reversal during a guard state switches to the opposite guard state and reloads the counter. The counter is never cut short.
- rf_switch_override=1 forces the FSM to RX_GUARD (from TX or TX_GUARD) and then holds it in RX; tdd_tx is ignored. Clearing the override resumes normal operation on the next cycle.

Registered outputs, 1 cycle after the state:
- pa_en_o = (state==TX && pa_lna_en[0] && pa_resetn) ? tdd_ctrl_pa : 0.
- lna_en_o = (state==RX && pa_lna_en[1]) ? ~bypass_lna : 0.
- Both are 0 in either guard state; PA and LNA are never enabled in the same cycle.

RX DSA:
- rxdsa_o[i] loads ps_rxdsa[i] only when state != RX. This means no gain step occurs mid-receive.
- Exception: with rf_switch_override=1 the load happens every cycle.
- pl_rxdsa mirrors rxdsa_o, registered, one cycle later.

Cold reset:
- Trigger: a falling edge of cold_rst_n (registered compare) while cold_rst_n_mask=0.
- Action: drive cold_rst_pin_n low for exactly RST_PULSE_CYCLES cycles.
- Edges during an active pulse are ignored; there is no retrigger.
- If cold_rst_n_mask is set mid-pulse, the pulse still completes.
- A level held low does not repeat the pulse.

Widths:
- Guard counter is 16 bits, matching ant_switch_delay.
- Debounce and pulse counters are sized with $clog2(param+1).

Decomposition:
- Shared package jb_hw_ctrl_pkg holds:
  - tdd_state_t enum {RX, TX_GUARD, TX, RX_GUARD};
  - NUM_CH=8, DSA_W=7, DSA_MAX=7'h7F;
  - the cal_sw bit-index constants.
- One sub-module, jb_sync_debounce (SYNC_STAGES, DEBOUNCE_CYCLES, reset value 0), instantiated 9 times for the pgood bits. Plain synchronizers reuse it with DEBOUNCE_CYCLES=0.

Test Plan:
1. Release rst with pins idle -> rxdsa_o=7F, pgood=0, cold_rst_pin_n=1, pa_en_o=0. Set pa_v_pgood_pin=8'hFF -> hw_ctrl.pa_v_pgood=FF exactly SYNC_STAGES+1024 cycles later. Glitch one bit low for 1 cycle at count 500 -> filter restarts.
2. ant_switch_delay=10, pa_lna_en=3, tdd_ctrl_pa=8'h0F, pa_resetn=1; toggle tdd_tx_pin 0->1 -> lna_en_o=0 immediately, 10 guard cycles, then pa_en_o=0F. 1->0 -> pa_en_o=0, 10 cycles, lna_en_o=~bypass_lna.
3. ant_switch_delay=0 -> 1-cycle guard; tdd reversal mid-guard at delay=100 -> counter reloads, PA never on.
4. ps_rxdsa[0]=7'h20 written during RX -> rxdsa_o unchanged until TX_GUARD, then 20 and pl_rxdsa[0]=20 one cycle later. rf_switch_override=1 -> immediate update, FSM pinned in RX.
5. cold_rst_n 1->0 with mask=0 -> cold_rst_pin_n low for 256 cycles. Second edge at cycle 100 ignored. mask=1 -> no pulse.
6. Assert rst during TX and mid-pulse -> all outputs return to their reset values asynchronously; FSM=RX after release.
